// File: rtl/ysyx_23060077_trap_ctrl.sv
// Trap sequencer: decodes ecall/mret, strobes the CSR file, flushes younger
// stages, then holds a PC redirect to fetch until it is accepted.
module ysyx_23060077_trap_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_inst,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_mtvec,
    input  logic [DATA_WIDTH-1:0] i_mepc,
    output logic                  o_csr_ecall,
    output logic                  o_csr_mret,
    output logic [DATA_WIDTH-1:0] o_csr_pc,
    output logic [DATA_WIDTH-1:0] o_csr_inst,
    output logic                  o_flush,
    output logic                  o_redirect_valid,
    output logic [DATA_WIDTH-1:0] o_redirect_pc,
    input  logic                  i_redirect_ready,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_trap_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        SETTLE,
        REDIRECT
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic                  kind_reg;     // 0 = ecall, 1 = mret
    logic [DATA_WIDTH-1:0] csr_pc_reg;
    logic [DATA_WIDTH-1:0] csr_inst_reg;
    logic [DATA_WIDTH-1:0] redirect_pc_reg;
    logic [CNT_WIDTH-1:0]  trap_cnt_reg;

    logic is_sys;
    logic is_ecall;
    logic is_mret;
    logic take_trap;
    logic redirect_done;

    assign is_sys    = (i_inst[6:0] == 7'b1110011) && (i_inst[14:12] == 3'b000);
    assign is_ecall  = is_sys && (i_inst[31:7] == 25'd0);
    assign is_mret   = is_sys && (i_inst[31:20] == 12'h302) && (i_inst[19:7] == 13'd0);
    assign take_trap = i_valid && o_ready && (is_ecall || is_mret);
    assign redirect_done = (state_reg == REDIRECT) && i_redirect_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (take_trap) state_next = COMMIT;
            COMMIT:   state_next = SETTLE;
            SETTLE:   state_next = REDIRECT;
            REDIRECT: if (i_redirect_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign o_ready          = (state_reg == IDLE);
    assign o_busy           = (state_reg != IDLE);
    assign o_csr_ecall      = (state_reg == COMMIT) && !kind_reg;
    assign o_csr_mret       = (state_reg == COMMIT) && kind_reg;
    assign o_flush          = (state_reg == COMMIT);
    assign o_redirect_valid = (state_reg == REDIRECT);
    assign o_csr_pc         = csr_pc_reg;
    assign o_csr_inst       = csr_inst_reg;
    assign o_redirect_pc    = redirect_pc_reg;
    assign o_trap_cnt       = trap_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            kind_reg        <= 1'b0;
            csr_pc_reg      <= '0;
            csr_inst_reg    <= '0;
            redirect_pc_reg <= '0;
            trap_cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (take_trap) begin
                kind_reg     <= is_mret;
                csr_pc_reg   <= i_pc;
                csr_inst_reg <= i_inst;
            end
            // Target is sampled only when leaving SETTLE, after the CSR writes
            // from COMMIT are visible, and then frozen through REDIRECT.
            if (state_reg == SETTLE) begin
                redirect_pc_reg <= kind_reg ? i_mepc : {i_mtvec[DATA_WIDTH-1:2], 2'b00};
            end
            if (redirect_done) begin
                trap_cnt_reg <= trap_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_trap_ctrl.sv
// Randomized self-checking bench for ysyx_23060077_trap_ctrl; expectations come
// from a cycle-timeline model of one transaction plus a decode function.
module tb_ysyx_23060077_trap_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_inst;
    logic [DW-1:0] i_pc;
    logic [DW-1:0] i_mtvec;
    logic [DW-1:0] i_mepc;
    logic          o_csr_ecall;
    logic          o_csr_mret;
    logic [DW-1:0] o_csr_pc;
    logic [DW-1:0] o_csr_inst;
    logic          o_flush;
    logic          o_redirect_valid;
    logic [DW-1:0] o_redirect_pc;
    logic          i_redirect_ready;
    logic          o_busy;
    logic [CW-1:0] o_trap_cnt;

    always #5 clk = ~clk;

    ysyx_23060077_trap_ctrl #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_inst          (i_inst),
        .i_pc            (i_pc),
        .i_mtvec         (i_mtvec),
        .i_mepc          (i_mepc),
        .o_csr_ecall     (o_csr_ecall),
        .o_csr_mret      (o_csr_mret),
        .o_csr_pc        (o_csr_pc),
        .o_csr_inst      (o_csr_inst),
        .o_flush         (o_flush),
        .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc   (o_redirect_pc),
        .i_redirect_ready(i_redirect_ready),
        .o_busy          (o_busy),
        .o_trap_cnt      (o_trap_cnt)
    );

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference state: count of completed redirects and last latched trap.
    logic [CW-1:0] exp_cnt;
    logic [DW-1:0] exp_csr_pc;
    logic [DW-1:0] exp_csr_inst;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 0 = plain, 1 = ecall, 2 = mret
    function automatic int kind_of(input logic [31:0] inst);
        logic sys;
        sys = (inst[6:0] == 7'h73) && (inst[14:12] == 3'd0);
        if (sys && inst[31:7] == 25'd0) return 1;
        if (sys && inst[31:20] == 12'h302 && inst[19:7] == 13'd0) return 2;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_rv"}, 32'(o_redirect_valid), 32'd0);
        chk({tag, "_strb"}, 32'({o_csr_ecall, o_csr_mret, o_flush}), 32'd0);
        chk({tag, "_cnt"}, 32'(o_trap_cnt), 32'(exp_cnt));
    endtask

    // One full transaction: present inst, walk the expected timeline, accept
    // the redirect after 'stall' refused cycles. 'hold' keeps an extra ecall
    // on i_valid while busy, which must be ignored.
    task automatic run_inst(input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] tv, input logic [31:0] ep,
                            input int stall, input bit hold);
        int k;
        logic [31:0] target;
        k = kind_of(inst);
        txn++;
        $display("txn %0d inst=%h pc=%h kind=%0d stall=%0d hold=%0d", txn, inst, pc, k, stall, hold);
        chk("pre_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_inst = inst; i_pc = pc;
        i_mtvec = tv; i_mepc = ep; i_redirect_ready = 1'b0;
        step();
        i_valid = 1'b0;
        if (k == 0) begin
            chk_idle("plain");
            chk("plain_csr_pc", o_csr_pc, exp_csr_pc);
        end else begin
            exp_csr_pc = pc;
            exp_csr_inst = inst;
            chk("commit_ecall", 32'(o_csr_ecall), 32'(k == 1));
            chk("commit_mret", 32'(o_csr_mret), 32'(k == 2));
            chk("commit_flush", 32'(o_flush), 32'd1);
            chk("commit_pc", o_csr_pc, exp_csr_pc);
            chk("commit_inst", o_csr_inst, exp_csr_inst);
            chk("commit_ready", 32'(o_ready), 32'd0);
            chk("commit_rv", 32'(o_redirect_valid), 32'd0);
            if (hold) begin
                i_valid = 1'b1; i_inst = 32'h0000_0073; i_pc = pc ^ 32'h0000_0100;
            end
            i_mtvec = ~tv; i_mepc = ~ep;
            step();
            chk("settle_strb", 32'({o_csr_ecall, o_csr_mret, o_flush}), 32'd0);
            chk("settle_rv", 32'(o_redirect_valid), 32'd0);
            chk("settle_busy", 32'(o_busy), 32'd1);
            i_mtvec = tv; i_mepc = ep;
            target = (k == 2) ? ep : {tv[31:2], 2'b00};
            step();
            for (int s = 0; s <= stall; s++) begin
                chk("redir_valid", 32'(o_redirect_valid), 32'd1);
                chk("redir_pc", o_redirect_pc, target);
                chk("redir_ready", 32'(o_ready), 32'd0);
                chk("redir_csr_pc", o_csr_pc, exp_csr_pc);
                i_mtvec = $urandom; i_mepc = $urandom;
                i_redirect_ready = (s == stall);
                if (s == stall) i_valid = 1'b0;
                step();
            end
            i_redirect_ready = 1'b0;
            exp_cnt = exp_cnt + 1'b1;
            chk_idle("done");
            chk("done_csr_pc", o_csr_pc, exp_csr_pc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = '0; exp_csr_pc = '0; exp_csr_inst = '0;
    endtask

    // Reset pulse while in SETTLE (phase 0) or REDIRECT (phase 1).
    task automatic reset_in(input int phase);
        txn++;
        $display("txn %0d reset during %s", txn, phase == 0 ? "SETTLE" : "REDIRECT");
        i_valid = 1'b1; i_inst = 32'h0000_0073; i_pc = 32'h8000_0200;
        i_mtvec = 32'h8000_0300; i_redirect_ready = 1'b0;
        step();
        i_valid = 1'b0;
        step();
        if (phase == 1) begin
            step();
            chk("rst_pre_rv", 32'(o_redirect_valid), 32'd1);
        end
        i_redirect_ready = 1'b1;
        do_reset();
        i_redirect_ready = 1'b0;
        chk_idle("rst");
        chk("rst_csr_pc", o_csr_pc, 32'd0);
        chk("rst_csr_inst", o_csr_inst, 32'd0);
        chk("rst_redir_pc", o_redirect_pc, 32'd0);
        step();
        chk_idle("rst_after");
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_inst = '0; i_pc = '0;
        i_mtvec = '0; i_mepc = '0; i_redirect_ready = 1'b0;
        exp_cnt = '0; exp_csr_pc = '0; exp_csr_inst = '0;
        step();
        do_reset();
        chk_idle("reset");
        chk("reset_csr_pc", o_csr_pc, 32'd0);
        chk("reset_redir_pc", o_redirect_pc, 32'd0);

        run_inst(32'h0000_0073, 32'h8000_0010, 32'h8000_0103, 32'h1234_5678, 0, 1'b0);
        chk("t1_cnt", 32'(o_trap_cnt), 32'd1);
        run_inst(32'h3020_0073, 32'h8000_0020, 32'hdead_beef, 32'h8000_0014, 0, 1'b0);
        run_inst(32'h0010_0073, 32'h8000_0030, 32'h0, 32'h0, 0, 1'b0);
        run_inst(32'h0000_0013, 32'h8000_0034, 32'h0, 32'h0, 0, 1'b0);
        run_inst(32'h0000_0073, 32'h8000_0040, 32'h8000_0201, 32'h0, 10, 1'b1);

        reset_in(0);
        reset_in(1);

        for (int i = 0; i < 17; i++)
            run_inst(32'h0000_0073, 32'h8000_1000 + 32'(i * 4), $urandom, $urandom, 0, 1'b0);
        chk("wrap_cnt", 32'(o_trap_cnt), 32'd1);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] inst;
            int sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1: inst = 32'h0000_0073;
                2: inst = 32'h3020_0073;
                3: inst = $urandom;
                4: inst = $urandom_range(0, 1) ? (32'h0000_0073 | (32'h80 << $urandom_range(0, 24)))
                                               : (32'h3020_0073 | (32'h1000 << $urandom_range(0, 2)));
                default: inst = 32'h0010_0073;
            endcase
            run_inst(inst, $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                step();
                chk_idle("gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
